// File: rtl/mont_exp_seq.sv
// Montgomery exponentiation sequencer: res = x^e mod m using one external
// Montgomery multiplier, in square-and-multiply or constant-time ladder mode.
module mont_exp_seq #(
  parameter int WIDTH     = 512,
  parameter int EXP_WIDTH = 512,
  parameter int CNT_W     = $clog2(EXP_WIDTH+1)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [EXP_WIDTH-1:0] in_e,
  input  logic [CNT_W-1:0]     e_len,
  input  logic [WIDTH-1:0]     in_m,
  input  logic [WIDTH-1:0]     in_r,
  input  logic [WIDTH-1:0]     in_r2,
  output logic [WIDTH-1:0]     res,
  output logic                 done,
  output logic                 busy,
  output logic                 mul_start,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  output logic [WIDTH-1:0]     mul_m,
  input  logic [WIDTH-1:0]     mul_res,
  input  logic                 mul_done
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_XT_ISSUE,
    S_XT_WAIT,
    S_SQ_ISSUE,
    S_SQ_WAIT,
    S_MUL_ISSUE,
    S_MUL_WAIT,
    S_LAD1_ISSUE,
    S_LAD1_WAIT,
    S_LAD2_ISSUE,
    S_LAD2_WAIT,
    S_FINAL_ISSUE,
    S_FINAL_WAIT,
    S_DONE
  } state_t;

  state_t               state;
  state_t               nxt_state;
  logic [EXP_WIDTH-1:0] e_q;
  logic                 mode_q;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     nxt_cnt;
  logic [CNT_W-1:0]     len_in;
  logic [WIDTH-1:0]     xt_q;
  logic [WIDTH-1:0]     acc_a;
  logic [WIDTH-1:0]     acc_b;
  logic [WIDTH-1:0]     nxt_a;
  logic [WIDTH-1:0]     nxt_b;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic [EXP_WIDTH-1:0] bit_mask;
  logic                 cur_bit;
  logic                 bit_end;
  logic                 go_loop;
  logic                 go_final;

  assign len_in = (e_len > CNT_W'(EXP_WIDTH)) ?
                  CNT_W'(EXP_WIDTH) : e_len;

  // cnt counts bits still to process; the current bit is e[cnt-1]
  assign bit_mask = {{(EXP_WIDTH-1){1'b0}}, 1'b1}
                    << (cnt - CNT_W'(1));
  assign cur_bit  = |(e_q & bit_mask);

  always_comb begin
    nxt_state = state;
    nxt_a     = acc_a;
    nxt_b     = acc_b;
    nxt_cnt   = cnt;
    op_a      = '0;
    op_b      = '0;
    bit_end   = 1'b0;
    go_loop   = 1'b0;
    go_final  = 1'b0;
    unique case (state)
      S_XT_WAIT: begin
        nxt_b = mul_res;
        if (cnt == '0) go_final = 1'b1;
        else           go_loop  = 1'b1;
      end
      S_SQ_WAIT: begin
        nxt_a = mul_res;
        if (cur_bit) begin
          nxt_state = S_MUL_ISSUE;
          op_a      = mul_res;
          op_b      = xt_q;
        end else begin
          bit_end = 1'b1;
        end
      end
      S_MUL_WAIT: begin
        nxt_a   = mul_res;
        bit_end = 1'b1;
      end
      S_LAD1_WAIT: begin
        if (cur_bit) nxt_a = mul_res;
        else         nxt_b = mul_res;
        // second ladder op squares the operand the first op left alone
        nxt_state = S_LAD2_ISSUE;
        op_a      = cur_bit ? acc_b : acc_a;
        op_b      = cur_bit ? acc_b : acc_a;
      end
      S_LAD2_WAIT: begin
        if (cur_bit) nxt_b = mul_res;
        else         nxt_a = mul_res;
        bit_end = 1'b1;
      end
      S_FINAL_WAIT: nxt_state = S_DONE;
      default: ;
    endcase
    if (bit_end) begin
      if (cnt == CNT_W'(1)) begin
        go_final = 1'b1;
      end else begin
        go_loop = 1'b1;
        nxt_cnt = cnt - CNT_W'(1);
      end
    end
    if (go_final) begin
      nxt_state = S_FINAL_ISSUE;
      op_a      = nxt_a;
      op_b      = WIDTH'(1);
    end
    if (go_loop) begin
      nxt_state = mode_q ? S_LAD1_ISSUE : S_SQ_ISSUE;
      op_a      = nxt_a;
      op_b      = mode_q ? nxt_b : nxt_a;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      res       <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_m     <= '0;
      e_q       <= '0;
      mode_q    <= 1'b0;
      cnt       <= '0;
      xt_q      <= '0;
      acc_a     <= '0;
      acc_b     <= '0;
    end else begin
      mul_start <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_XT_ISSUE;
            e_q       <= in_e;
            mode_q    <= mode;
            cnt       <= len_in;
            acc_a     <= in_r;
            acc_b     <= '0;
            mul_start <= 1'b1;
            mul_a     <= in_x;
            mul_b     <= in_r2;
            mul_m     <= in_m;
            done      <= 1'b0;
            busy      <= 1'b1;
          end
        end
        S_XT_ISSUE:    state <= S_XT_WAIT;
        S_SQ_ISSUE:    state <= S_SQ_WAIT;
        S_MUL_ISSUE:   state <= S_MUL_WAIT;
        S_LAD1_ISSUE:  state <= S_LAD1_WAIT;
        S_LAD2_ISSUE:  state <= S_LAD2_WAIT;
        S_FINAL_ISSUE: state <= S_FINAL_WAIT;
        S_XT_WAIT, S_SQ_WAIT, S_MUL_WAIT,
        S_LAD1_WAIT, S_LAD2_WAIT, S_FINAL_WAIT: begin
          if (mul_done) begin
            state <= nxt_state;
            acc_a <= nxt_a;
            acc_b <= nxt_b;
            cnt   <= nxt_cnt;
            if (state == S_XT_WAIT) xt_q <= mul_res;
            if (nxt_state == S_DONE) begin
              res  <= mul_res;
              done <= 1'b1;
              busy <= 1'b0;
            end else begin
              mul_start <= 1'b1;
              mul_a     <= op_a;
              mul_b     <= op_b;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_exp_seq.sv
// Directed bench for mont_exp_seq with a behavioural Montgomery multiplier
// (latency 3) and an integer modexp reference model.
module tb_mont_exp_seq;

  localparam int W  = 16;
  localparam int EW = 16;
  localparam int CW = 5;
  localparam int L  = 3;
  localparam logic [W-1:0] M  = 16'd241;
  localparam logic [W-1:0] R  = 16'd225;
  localparam logic [W-1:0] R2 = 16'd15;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [W-1:0]  in_x = '0;
  logic [EW-1:0] in_e = '0;
  logic [CW-1:0] e_len = '0;
  logic [W-1:0]  res;
  logic          done;
  logic          busy;
  logic          mul_start;
  logic [W-1:0]  mul_a;
  logic [W-1:0]  mul_b;
  logic [W-1:0]  mul_m;
  logic [W-1:0]  mul_res;
  logic          mul_done;

  logic          stray = 1'b0;
  logic          m_done;
  logic [W-1:0]  m_res;
  logic [W-1:0]  m_prod;
  logic          m_pend;
  int            m_cnt;

  int checks = 0;
  int errors = 0;
  int nstart = 0;

  mont_exp_seq #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .mode(mode),
    .in_x(in_x), .in_e(in_e), .e_len(e_len), .in_m(M),
    .in_r(R), .in_r2(R2), .res(res), .done(done), .busy(busy),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_m(mul_m), .mul_res(mul_res), .mul_done(mul_done)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mont(input logic [W-1:0] a,
                                        input logic [W-1:0] b,
                                        input logic [W-1:0] m);
    logic [33:0] t;
    t = 34'(a) * 34'(b);
    for (int i = 0; i < W; i++) begin
      if (t[0]) t = t + 34'(m);
      t = t >> 1;
    end
    if (t >= 34'(m)) t = t - 34'(m);
    return t[W-1:0];
  endfunction

  function automatic int unsigned modpow(input int unsigned x,
                                         input logic [15:0] e,
                                         input int len);
    int unsigned r;
    r = 1;
    for (int i = len - 1; i >= 0; i--) begin
      r = (r * r) % 241;
      if (e[i]) r = (r * x) % 241;
    end
    return r;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_pend <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
      m_res  <= '0;
      m_prod <= '0;
    end else begin
      m_done <= 1'b0;
      if (mul_start) begin
        m_pend <= 1'b1;
        m_cnt  <= L - 1;
        m_prod <= mont(mul_a, mul_b, mul_m);
      end else if (m_pend) begin
        if (m_cnt == 1) begin
          m_done <= 1'b1;
          m_res  <= m_prod;
          m_pend <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  assign mul_done = m_done | stray;
  assign mul_res  = m_res;

  always @(posedge clk) if (mul_start === 1'b1) nstart++;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic run(input string tag, input logic [15:0] x,
                     input logic [15:0] e, input logic [4:0] el,
                     input logic md, input int eff,
                     input int want_cyc, input int want_ops,
                     input bit glitch);
    int cyc;
    logic [W-1:0] want;
    want = W'(modpow(32'(x), e, eff));
    @(posedge clk); #1;
    in_x = x;
    in_e = e;
    e_len = el;
    mode = md;
    start = 1'b1;
    nstart = 0;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    chk({tag, " busy_set"}, 32'(busy), 1);
    chk({tag, " done_clr"}, 32'(done), 0);
    while (done !== 1'b1 && cyc < 400) begin
      start = glitch && (cyc == 3 || cyc == 14);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk({tag, " cycles"}, cyc, want_cyc);
    chk({tag, " res"}, 32'(res), 32'(want));
    chk({tag, " ops"}, nstart, want_ops);
    chk({tag, " busy_end"}, 32'(busy), 0);
    chk({tag, " mul_m"}, 32'(mul_m), 32'(M));
    repeat (3) @(posedge clk);
    #1;
    chk({tag, " res_hold"}, 32'(res), 32'(want));
    chk({tag, " done_hold"}, 32'(done), 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst res", 32'(res), 0);
    chk("rst done", 32'(done), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst mul_start", 32'(mul_start), 0);
    chk("rst mul_a", 32'(mul_a), 0);
    chk("rst mul_m", 32'(mul_m), 0);
    resetn = 1'b1;

    run("sqm_e11", 16'd5, 16'h000B, 5'd4, 1'b0, 4, 37, 9, 1'b0);
    run("sqm_len8", 16'd5, 16'h000B, 5'd8, 1'b0, 8, 53, 13, 1'b0);
    run("lad_e11", 16'd5, 16'h000B, 5'd4, 1'b1, 4, 41, 10, 1'b0);
    run("lad_e8", 16'd5, 16'h0008, 5'd4, 1'b1, 4, 41, 10, 1'b0);
    run("lad_e15", 16'd5, 16'h000F, 5'd4, 1'b1, 4, 41, 10, 1'b0);
    run("len0", 16'd5, 16'h000B, 5'd0, 1'b0, 0, 9, 2, 1'b0);
    run("e0", 16'd5, 16'h0000, 5'd4, 1'b0, 4, 25, 6, 1'b0);
    run("clamp", 16'd5, 16'h000B, 5'd31, 1'b0, 16, 85, 21, 1'b0);
    run("sqm_big", 16'd200, 16'hA5C3, 5'd16, 1'b0, 16, 105, 26, 1'b0);
    run("lad_big", 16'd200, 16'hA5C3, 5'd16, 1'b1, 16, 137, 34, 1'b0);
    run("glitch", 16'd5, 16'h000B, 5'd4, 1'b0, 4, 37, 9, 1'b1);

    @(posedge clk); #1;
    in_x = 16'd5;
    in_e = 16'h000B;
    e_len = 5'd4;
    mode = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("midrst res", 32'(res), 0);
    chk("midrst done", 32'(done), 0);
    chk("midrst busy", 32'(busy), 0);
    chk("midrst mul_start", 32'(mul_start), 0);
    chk("midrst mul_a", 32'(mul_a), 0);
    chk("midrst mul_b", 32'(mul_b), 0);
    chk("midrst mul_m", 32'(mul_m), 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    nstart = 0;
    @(posedge clk); #1;
    stray = 1'b1;
    @(posedge clk); #1;
    stray = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("stray done", 32'(done), 0);
    chk("stray busy", 32'(busy), 0);
    chk("stray ops", nstart, 0);
    chk("stray res", 32'(res), 0);

    run("post_rst", 16'd5, 16'h000B, 5'd4, 1'b0, 4, 37, 9, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
